// File: rtl/mod_segment_transition_pkg.sv
// Shared types for the modulation segment transition logic.
package mod_segment_transition_pkg;

    localparam int          IdxWidth    = 15;
    localparam logic [15:0] RepInfinite = 16'hFFFF;

    // Transition mode codes as written into the ADDR_MOD_* control registers.
    typedef enum logic [7:0] {
        TRANS_SYNC_IDX = 8'h00,
        TRANS_SYS_TIME = 8'h01,
        TRANS_GPIO     = 8'h02,
        TRANS_EXT      = 8'hF0
    } transition_mode_t;

    // Segment controller state; also used by the STM variant.
    typedef enum logic [1:0] {
        RUN_INF,
        WAIT_TRANS,
        RUN_FINITE,
        EXT_LOOP
    } mod_trans_state_t;

    // Settings captured on UPDATE_SETTINGS and held until the next update.
    // The mode stays a raw byte so unknown codes are kept as written.
    typedef struct packed {
        logic        req_segment;
        logic [15:0] rep;
        logic [7:0]  mode;
        logic [63:0] value;
    } mod_settings_t;

    // A request loops forever (and switches at once) unless it is an EXT request.
    function automatic logic is_immediate(input logic [15:0] rep, input logic [7:0] mode);
        return (rep == RepInfinite) && (mode != TRANS_EXT);
    endfunction

endpackage

// File: rtl/mod_segment_transition_idx_wrap_detect.sv
// Per-segment index wrap detector: the index counts up and returns to 0 after
// its last value, so a wrap shows as the index dropping below its previous value.
module idx_wrap_detect
    import mod_segment_transition_pkg::*;
#(
    parameter int IdxW = IdxWidth
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IdxW-1:0] IDX,
    output logic            WRAP
);

    logic [IdxW-1:0] idx_q;

    // Previous index, one cycle behind the live input.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) idx_q <= '0;
        else     idx_q <= IDX;
    end

    // High for exactly the cycle in which the index has gone backwards.
    assign WRAP = (IDX < idx_q);

endmodule

// File: rtl/mod_segment_transition.sv
// Active modulation segment selection and segment change sequencing.
module mod_segment_transition
    import mod_segment_transition_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                UPDATE_SETTINGS,
    input  logic                REQ_RD_SEGMENT,
    input  logic [15:0]         REP,
    input  logic [7:0]          TRANSITION_MODE,
    input  logic [63:0]         TRANSITION_VALUE,
    input  logic [IdxWidth-1:0] CYCLE0,
    input  logic [IdxWidth-1:0] CYCLE1,
    input  logic [IdxWidth-1:0] IDX0,
    input  logic [IdxWidth-1:0] IDX1,
    input  logic [63:0]         SYS_TIME,
    input  logic [3:0]          GPIO_IN,
    output logic                SEGMENT,
    output logic                STOP
);

    localparam int NumSeg = 2;

    mod_trans_state_t state_q, state_d;
    mod_settings_t    pend_q;
    logic             seg_q, seg_d;
    logic             stop_q, stop_d;
    logic [15:0]      loop_q, loop_d;
    logic [3:0]       gpio_q;

    logic [NumSeg-1:0][IdxWidth-1:0] idx_vec;
    logic [NumSeg-1:0]               wrap_vec;
    logic                            wrap_act;
    logic                            fire;
    logic [1:0]                      gpio_sel;

    // Wrap is decided purely by index motion; the cycle lengths are not needed.
    logic unused_cycle;
    assign unused_cycle = ^{CYCLE0, CYCLE1};

    assign idx_vec = {IDX1, IDX0};

    idx_wrap_detect #(.IdxW(IdxWidth)) u_wrap [NumSeg-1:0] (
        .CLK  (CLK),
        .RST  (RST),
        .IDX  (idx_vec),
        .WRAP (wrap_vec)
    );

    // Wrap of the segment that is active now, before any change this cycle.
    assign wrap_act = seg_q ? wrap_vec[1] : wrap_vec[0];
    assign gpio_sel = pend_q.value[1:0];

    // Transition trigger, evaluated against the pending settings.
    always_comb begin
        fire = 1'b0;
        case (pend_q.mode)
            TRANS_SYNC_IDX: fire = wrap_act;
            TRANS_SYS_TIME: fire = (SYS_TIME >= pend_q.value);
            TRANS_GPIO:     fire = GPIO_IN[gpio_sel] & ~gpio_q[gpio_sel];
            default:        fire = 1'b0;
        endcase
    end

    // Pending settings capture and GPIO edge history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= '0;
            gpio_q <= '0;
        end else begin
            gpio_q <= GPIO_IN;
            if (UPDATE_SETTINGS) begin
                pend_q.req_segment <= REQ_RD_SEGMENT;
                pend_q.rep         <= REP;
                pend_q.mode        <= TRANSITION_MODE;
                pend_q.value       <= TRANSITION_VALUE;
            end
        end
    end

    // State register together with the registered outputs and loop counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN_INF;
            seg_q   <= 1'b0;
            stop_q  <= 1'b0;
            loop_q  <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            stop_q  <= stop_d;
            loop_q  <= loop_d;
        end
    end

    // Next state: a new update always overrides whatever the FSM was doing.
    always_comb begin
        state_d = state_q;
        if (UPDATE_SETTINGS) begin
            if (TRANSITION_MODE == TRANS_EXT)                state_d = EXT_LOOP;
            else if (is_immediate(REP, TRANSITION_MODE))     state_d = RUN_INF;
            else                                             state_d = WAIT_TRANS;
        end else if ((state_q == WAIT_TRANS) && fire) begin
            state_d = RUN_FINITE;
        end
    end

    // Segment, stop flag and loop counter updates for the current state.
    always_comb begin
        seg_d  = seg_q;
        stop_d = stop_q;
        loop_d = loop_q;
        if (UPDATE_SETTINGS) begin
            loop_d = '0;
            if (is_immediate(REP, TRANSITION_MODE) || (TRANSITION_MODE == TRANS_EXT)) begin
                seg_d  = REQ_RD_SEGMENT;
                stop_d = 1'b0;
            end
        end else begin
            case (state_q)
                WAIT_TRANS: begin
                    if (fire) begin
                        seg_d  = pend_q.req_segment;
                        stop_d = 1'b0;
                        loop_d = '0;
                    end
                end
                RUN_FINITE: begin
                    // Once stopped, the reader holds its last index; ignore further wraps.
                    if (wrap_act && !stop_q) begin
                        if (loop_q == pend_q.rep) stop_d = 1'b1;
                        else                      loop_d = loop_q + 16'd1;
                    end
                end
                EXT_LOOP: begin
                    if (wrap_act) seg_d = ~seg_q;
                end
                default: ;
            endcase
        end
    end

    assign SEGMENT = seg_q;
    assign STOP    = stop_q;

endmodule

// File: tb/tb_mod_segment_transition.sv
// Directed bench for mod_segment_transition.
module tb_mod_segment_transition;
    import mod_segment_transition_pkg::*;

    logic                CLK = 1'b0;
    logic                RST;
    logic                UPDATE_SETTINGS;
    logic                REQ_RD_SEGMENT;
    logic [15:0]         REP;
    logic [7:0]          TRANSITION_MODE;
    logic [63:0]         TRANSITION_VALUE;
    logic [IdxWidth-1:0] CYCLE0, CYCLE1, IDX0, IDX1;
    logic [63:0]         SYS_TIME;
    logic [3:0]          GPIO_IN;
    logic                SEGMENT, STOP;

    int tests = 0;
    int fails = 0;

    mod_segment_transition dut (
        .CLK(CLK), .RST(RST), .UPDATE_SETTINGS(UPDATE_SETTINGS),
        .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .REP(REP), .TRANSITION_MODE(TRANSITION_MODE),
        .TRANSITION_VALUE(TRANSITION_VALUE), .CYCLE0(CYCLE0), .CYCLE1(CYCLE1),
        .IDX0(IDX0), .IDX1(IDX1), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN),
        .SEGMENT(SEGMENT), .STOP(STOP)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        UPDATE_SETTINGS = 1'b0; REQ_RD_SEGMENT = 1'b0; REP = '0;
        TRANSITION_MODE = '0; TRANSITION_VALUE = '0;
        CYCLE0 = 15'd9; CYCLE1 = 15'd9; IDX0 = '0; IDX1 = '0;
        SYS_TIME = '0; GPIO_IN = '0;
        tick(); tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic do_update(input logic req, input logic [15:0] rep,
                             input logic [7:0] mode, input logic [63:0] val);
        UPDATE_SETTINGS = 1'b1; REQ_RD_SEGMENT = req; REP = rep;
        TRANSITION_MODE = mode; TRANSITION_VALUE = val;
        tick();
        UPDATE_SETTINGS = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        RST = 1'b1;
        tick();
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL reset_seg: got %b exp 0", SEGMENT); end
        tests++; if (STOP !== 1'b0) begin fails++; $display("FAIL reset_stop: got %b exp 0", STOP); end
        RST = 1'b0;
        tick();
        for (int i = 0; i < 25; i++) begin
            IDX0 = (IDX0 == CYCLE0) ? '0 : IDX0 + 15'd1;
            tick();
        end
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL run_seg: got %b exp 0", SEGMENT); end
        tests++; if (STOP !== 1'b0) begin fails++; $display("FAIL run_stop: got %b exp 0", STOP); end
        do_update(1'b1, RepInfinite, TRANS_SYNC_IDX, 64'd0);
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL pre_rst_seg: got %b exp 1", SEGMENT); end
        RST = 1'b1;
        #2;
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL async_rst_seg: got %b exp 0", SEGMENT); end
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_infinite();
        logic stop_seen;
        apply_reset();
        do_update(1'b1, RepInfinite, TRANS_SYNC_IDX, 64'd0);
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL inf_seg: got %b exp 1", SEGMENT); end
        CYCLE1 = 15'd4;
        stop_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            IDX1 = (IDX1 == CYCLE1) ? '0 : IDX1 + 15'd1;
            tick();
            stop_seen |= STOP;
        end
        tests++; if (stop_seen !== 1'b0) begin fails++; $display("FAIL inf_stop: got %b exp 0", stop_seen); end
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL inf_seg_hold: got %b exp 1", SEGMENT); end
    endtask

    task automatic test_finite();
        apply_reset();
        IDX0 = 15'd5; tick();
        do_update(1'b1, 16'd2, TRANS_SYNC_IDX, 64'd0);
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL fin_wait_seg: got %b exp 0", SEGMENT); end
        IDX0 = 15'd6; tick();
        IDX0 = 15'd0;
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL fin_pre_wrap: got %b exp 0", SEGMENT); end
        tick();
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL fin_switch: got %b exp 1", SEGMENT); end
        for (int w = 1; w <= 3; w++) begin
            IDX1 = 15'd3; tick();
            IDX1 = 15'd0; tick();
            tests++;
            if (STOP !== (w == 3)) begin fails++; $display("FAIL fin_stop_w%0d: got %b exp %b", w, STOP, (w == 3)); end
        end
        IDX1 = 15'd3; tick();
        IDX1 = 15'd0; tick();
        tests++; if (STOP !== 1'b1) begin fails++; $display("FAIL fin_stop_hold: got %b exp 1", STOP); end
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL fin_seg_hold: got %b exp 1", SEGMENT); end
    endtask

    task automatic test_sys_time();
        apply_reset();
        SYS_TIME = 64'd990;
        do_update(1'b1, 16'd0, TRANS_SYS_TIME, 64'd1000);
        for (int t = 991; t <= 1000; t++) begin
            SYS_TIME = 64'(t);
            tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL st_early_%0d: got %b exp 0", t, SEGMENT); end
            tick();
        end
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL st_switch: got %b exp 1", SEGMENT); end
        apply_reset();
        SYS_TIME = 64'd990;
        do_update(1'b1, 16'd0, TRANS_SYS_TIME, 64'd5);
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL st_past_upd: got %b exp 0", SEGMENT); end
        tick();
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL st_past_fire: got %b exp 1", SEGMENT); end
    endtask

    task automatic test_gpio();
        apply_reset();
        do_update(1'b1, 16'd0, TRANS_GPIO, 64'd2);
        GPIO_IN = 4'b0010; tick(); tick();
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL gpio_wrong_pin: got %b exp 0", SEGMENT); end
        GPIO_IN = 4'b0000; tick();
        GPIO_IN = 4'b0100;
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL gpio_pre_edge: got %b exp 0", SEGMENT); end
        tick();
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL gpio_fire: got %b exp 1", SEGMENT); end
        // REP=0 means a single loop of the new segment.
        IDX1 = 15'd3; tick();
        IDX1 = 15'd0; tick();
        tests++; if (STOP !== 1'b1) begin fails++; $display("FAIL gpio_rep0_stop: got %b exp 1", STOP); end
        do_update(1'b0, 16'd0, TRANS_GPIO, 64'd2);
        tick(); tick(); tick();
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL gpio_level: got %b exp 1", SEGMENT); end
        GPIO_IN = 4'b0000; tick();
        GPIO_IN = 4'b0100; tick();
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL gpio_refire_seg: got %b exp 0", SEGMENT); end
        tests++; if (STOP !== 1'b0) begin fails++; $display("FAIL gpio_refire_stop: got %b exp 0", STOP); end
    endtask

    task automatic test_ext();
        apply_reset();
        CYCLE0 = 15'd3; CYCLE1 = 15'd5;
        do_update(1'b1, 16'd0, TRANS_EXT, 64'd0);
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL ext_start: got %b exp 1", SEGMENT); end
        IDX1 = 15'd5; tick();
        IDX1 = 15'd0; tick();
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL ext_tog1: got %b exp 0", SEGMENT); end
        IDX1 = 15'd5; tick();
        IDX1 = 15'd0; tick();
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL ext_inactive: got %b exp 0", SEGMENT); end
        IDX0 = 15'd3; tick();
        IDX0 = 15'd0; tick();
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL ext_tog2: got %b exp 1", SEGMENT); end
        tests++; if (STOP !== 1'b0) begin fails++; $display("FAIL ext_stop: got %b exp 0", STOP); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        IDX0 = 15'd2; tick();
        do_update(1'b1, 16'd0, TRANS_SYNC_IDX, 64'd0);
        IDX0 = 15'd0;
        do_update(1'b1, 16'd5, TRANS_GPIO, 64'd0);
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL b2b_wrap_lost: got %b exp 0", SEGMENT); end
        IDX0 = 15'd2; tick();
        IDX0 = 15'd0; tick();
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL b2b_new_mode: got %b exp 0", SEGMENT); end
        GPIO_IN = 4'b0001; tick();
        tests++; if (SEGMENT !== 1'b1) begin fails++; $display("FAIL b2b_gpio_fire: got %b exp 1", SEGMENT); end
    endtask

    task automatic test_unknown_mode();
        apply_reset();
        IDX0 = 15'd4; tick();
        do_update(1'b1, 16'd0, 8'h07, 64'd0);
        IDX0 = 15'd0; tick();
        IDX0 = 15'd4; tick();
        IDX0 = 15'd0; GPIO_IN = 4'b1111; SYS_TIME = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        tests++; if (SEGMENT !== 1'b0) begin fails++; $display("FAIL unk_no_fire: got %b exp 0", SEGMENT); end
    endtask

    initial begin
        test_reset();
        test_infinite();
        test_finite();
        test_sys_time();
        test_gpio();
        test_ext();
        test_back_to_back();
        test_unknown_mode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
